mine_field_ctrl: RTL and testbench

- Game controller for the 8x16 minesweeper board.
- On start it seeds the mine field from a free-running LFSR, placing exactly MINES_PER_ROW mines per row and rejecting collisions.
- It then serves one reveal request at a time: reports a mine hit, or the count of mines in the 8 neighbouring cells.
- It tracks revealed cells, detects win/loss, and drives the timer's run/finish controls.

---
 rtl/mine_pkg.sv | 29 ++
 rtl/mine_field_ctrl_if.sv | 33 +++
 rtl/mine_lfsr16.sv | 23 ++
 rtl/mine_field_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mine_field_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mine_pkg.sv
// Shared constants, state encoding and neighbour scan table for the minesweeper controller.
package mine_pkg;
    localparam int ROWS          = 8;
    localparam int COLS          = 16;
    localparam int MINES_PER_ROW = 2;
    localparam int SAFE_CELLS    = ROWS*COLS - ROWS*MINES_PER_ROW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_READY,
        S_COUNT,
        S_RESP,
        S_LOST,
        S_WON
    } state_t;

    typedef struct packed {
        logic signed [1:0] dr;
        logic signed [1:0] dc;
    } offset_t;

    // Neighbour scan order: row above left to right, same row, then row below.
    localparam offset_t NBR_OFFSET [8] = '{
        '{-2'sd1, -2'sd1}, '{-2'sd1, 2'sd0}, '{-2'sd1, 2'sd1},
        '{ 2'sd0, -2'sd1},                   '{ 2'sd0, 2'sd1},
        '{ 2'sd1, -2'sd1}, '{ 2'sd1, 2'sd0}, '{ 2'sd1, 2'sd1}
    };
endpackage

// File: rtl/mine_field_ctrl_if.sv
// Request/response and status bundle between the game host and mine_field_ctrl.
interface mine_field_ctrl_if;
    logic        start;
    logic        load_valid;
    logic [2:0]  load_row;
    logic [15:0] load_data;
    logic        load_done;
    logic        reveal_valid;
    logic [2:0]  reveal_row;
    logic [3:0]  reveal_col;
    logic        reveal_ready;
    logic        result_valid;
    logic        result_mine;
    logic [3:0]  result_count;
    logic        field_ready;
    logic        timer_run;
    logic        finish;
    logic        win;

    modport master (
        output start, load_valid, load_row, load_data, load_done,
               reveal_valid, reveal_row, reveal_col,
        input  reveal_ready, result_valid, result_mine, result_count,
               field_ready, timer_run, finish, win
    );

    modport slave (
        input  start, load_valid, load_row, load_data, load_done,
               reveal_valid, reveal_row, reveal_col,
        output reveal_ready, result_valid, result_mine, result_count,
               field_ready, timer_run, finish, win
    );
endinterface

// File: rtl/mine_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) feeding mine placement.
module mine_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] o_lfsr
);
    logic [15:0] r_lfsr;
    logic        w_feedback;

    assign w_feedback = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_feedback};
        end
    end

    assign o_lfsr = r_lfsr;
endmodule

// File: rtl/mine_field_ctrl.sv
// Minesweeper game controller: seeds the field from an LFSR, answers reveal requests with
// mine/neighbour-count results, and tracks revealed cells for win/loss detection.
module mine_field_ctrl #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clock,
    input  logic             reset,
    mine_field_ctrl_if.slave bus
);
    import mine_pkg::*;

    localparam logic [1:0] LAST_PLACED = 2'(MINES_PER_ROW - 1);
    localparam logic [2:0] LAST_ROW    = 3'(ROWS - 1);
    localparam logic [7:0] LAST_SAFE   = 8'(SAFE_CELLS - 1);

    state_t                    r_state;
    state_t                    w_next;
    logic [15:0]               w_lfsr;
    logic                      w_unusedLfsr;
    logic [ROWS-1:0][COLS-1:0] r_mine;
    logic [ROWS-1:0][COLS-1:0] r_revealed;
    logic [7:0]                r_revealCnt;
    logic [2:0]                r_genRow;
    logic [1:0]                r_placed;
    logic [2:0]                r_row;
    logic [3:0]                r_col;
    logic [2:0]                r_k;
    logic [3:0]                r_sum;
    logic                      r_resultValid;
    logic                      r_resultMine;
    logic [3:0]                r_resultCount;
    logic [3:0]                w_cand;
    logic                      w_candFree;
    logic                      w_rowDone;
    logic                      w_hitMine;
    logic                      w_fresh;
    offset_t                   w_off;
    logic [4:0]                w_nr;
    logic [4:0]                w_nc;
    logic                      w_nbrMine;

    mine_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .o_lfsr (w_lfsr)
    );

    assign w_unusedLfsr = ^w_lfsr[15:4];
    assign w_cand       = w_lfsr[3:0];
    assign w_candFree   = !r_mine[r_genRow][w_cand];
    assign w_rowDone    = w_candFree && (r_placed == LAST_PLACED);
    assign w_hitMine    = r_mine[bus.reveal_row][bus.reveal_col];
    assign w_fresh      = !r_revealed[r_row][r_col];

    // Negative offsets wrap to >= 16 in 5 bits, so one unsigned compare rejects both board edges.
    assign w_off     = NBR_OFFSET[r_k];
    assign w_nr      = {2'b00, r_row} + {{3{w_off.dr[1]}}, w_off.dr};
    assign w_nc      = {1'b0, r_col} + {{3{w_off.dc[1]}}, w_off.dc};
    assign w_nbrMine = (w_nr < 5'(ROWS)) && (w_nc < 5'(COLS)) && r_mine[w_nr[2:0]][w_nc[3:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.start) begin
            w_next = S_GEN;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.load_done) w_next = S_READY;
                S_GEN:   if (w_rowDone && r_genRow == LAST_ROW) w_next = S_READY;
                S_READY: if (bus.reveal_valid) w_next = w_hitMine ? S_LOST : S_COUNT;
                S_COUNT: if (r_k == 3'd7) w_next = S_RESP;
                S_RESP:  w_next = (w_fresh && r_revealCnt == LAST_SAFE) ? S_WON : S_READY;
                default: ;
            endcase
        end
    end

    // Field, reveal tracking and result registers; start clears the game and drops any pending result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mine        <= '0;
            r_revealed    <= '0;
            r_revealCnt   <= '0;
            r_genRow      <= '0;
            r_placed      <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_k           <= '0;
            r_sum         <= '0;
            r_resultValid <= 1'b0;
            r_resultMine  <= 1'b0;
            r_resultCount <= '0;
        end else begin
            r_resultValid <= 1'b0;
            if (bus.start) begin
                r_mine      <= '0;
                r_revealed  <= '0;
                r_revealCnt <= '0;
                r_genRow    <= '0;
                r_placed    <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.load_valid) r_mine[bus.load_row] <= bus.load_data;
                    end
                    S_GEN: begin
                        if (w_candFree) begin
                            r_mine[r_genRow][w_cand] <= 1'b1;
                            if (w_rowDone) begin
                                r_placed <= '0;
                                r_genRow <= r_genRow + 3'd1;
                            end else begin
                                r_placed <= r_placed + 2'd1;
                            end
                        end
                    end
                    S_READY: begin
                        if (bus.reveal_valid) begin
                            r_row <= bus.reveal_row;
                            r_col <= bus.reveal_col;
                            r_k   <= '0;
                            r_sum <= '0;
                            if (w_hitMine) begin
                                r_resultValid <= 1'b1;
                                r_resultMine  <= 1'b1;
                                r_resultCount <= 4'd15;
                            end
                        end
                    end
                    S_COUNT: begin
                        r_sum <= r_sum + {3'b000, w_nbrMine};
                        r_k   <= r_k + 3'd1;
                    end
                    S_RESP: begin
                        r_resultValid <= 1'b1;
                        r_resultMine  <= 1'b0;
                        r_resultCount <= r_sum;
                        if (w_fresh) begin
                            r_revealed[r_row][r_col] <= 1'b1;
                            r_revealCnt              <= r_revealCnt + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.reveal_ready = (r_state == S_READY);
    assign bus.field_ready  = r_state inside {S_READY, S_COUNT, S_RESP, S_LOST, S_WON};
    assign bus.timer_run    = r_state inside {S_READY, S_COUNT, S_RESP};
    assign bus.finish       = r_state inside {S_LOST, S_WON};
    assign bus.win          = (r_state == S_WON);
    assign bus.result_valid = r_resultValid;
    assign bus.result_mine  = r_resultMine;
    assign bus.result_count = r_resultCount;
endmodule

// File: tb/tb_mine_field_ctrl.sv
// Directed bench for mine_field_ctrl: reset, generation, reveal latency and counts,
// board edges, win detection, abort on start and asynchronous reset.
module tb_mine_field_ctrl;
    import mine_pkg::*;

    localparam logic [15:0] SEED = 16'hACE1;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    mine_field_ctrl_if bus ();

    mine_field_ctrl #(.LFSR_SEED(SEED)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clearInputs();
        bus.start        = 1'b0;
        bus.load_valid   = 1'b0;
        bus.load_row     = 3'd0;
        bus.load_data    = 16'd0;
        bus.load_done    = 1'b0;
        bus.reveal_valid = 1'b0;
        bus.reveal_row   = 3'd0;
        bus.reveal_col   = 4'd0;
    endtask

    task automatic hardReset();
        clearInputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic loadField(input logic [15:0] bits);
        hardReset();
        for (int r = 0; r < 8; r++) begin
            bus.load_valid = 1'b1;
            bus.load_row   = 3'(r);
            bus.load_data  = bits;
            step();
        end
        bus.load_valid = 1'b0;
        bus.load_done  = 1'b1;
        step();
        bus.load_done  = 1'b0;
    endtask

    // lat = edges from the accept edge (counted as 1) until result_valid is seen; 0 on timeout
    task automatic doReveal(input logic [2:0] row, input logic [3:0] col, output int lat);
        bus.reveal_valid = 1'b1;
        bus.reveal_row   = row;
        bus.reveal_col   = col;
        step();
        bus.reveal_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            if (bus.result_valid) begin
                lat = i;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        logic seen;
        clearInputs();
        reset = 1'b0;
        #12;
        checks++;
        if ({bus.reveal_ready, bus.result_valid, bus.result_mine, bus.field_ready,
             bus.timer_run, bus.finish, bus.win, bus.result_count} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b, expected all zero",
                     {bus.reveal_ready, bus.result_valid, bus.result_mine, bus.field_ready,
                      bus.timer_run, bus.finish, bus.win, bus.result_count});
        end
        checks++;
        if (dut.r_state !== S_IDLE) begin
            errors++;
            $display("[TB] FAIL reset_state: got %0d, expected %0d", dut.r_state, S_IDLE);
        end
        checks++;
        if (dut.u_lfsr.r_lfsr !== SEED) begin
            errors++;
            $display("[TB] FAIL reset_lfsr: got %h, expected %h", dut.u_lfsr.r_lfsr, SEED);
        end
        reset = 1'b1;
        step();
        bus.reveal_valid = 1'b1;
        bus.reveal_row   = 3'd3;
        bus.reveal_col   = 4'd5;
        seen = 1'b0;
        repeat (4) begin
            step();
            if (bus.result_valid) seen = 1'b1;
        end
        bus.reveal_valid = 1'b0;
        checks++;
        if (seen !== 1'b0 || dut.r_state !== S_IDLE) begin
            errors++;
            $display("[TB] FAIL idle_ignores_reveal: got valid=%0d state=%0d, expected 0 and %0d",
                     seen, dut.r_state, S_IDLE);
        end
    endtask

    task automatic test_gen();
        int cyc;
        clearInputs();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (dut.r_state !== S_GEN || bus.field_ready !== 1'b0 || bus.timer_run !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gen_entry: got state=%0d fr=%0d tr=%0d, expected %0d 0 0",
                     dut.r_state, bus.field_ready, bus.timer_run, S_GEN);
        end
        cyc = 0;
        while (!bus.field_ready && cyc < 2000) begin
            step();
            cyc++;
        end
        checks++;
        if (bus.field_ready !== 1'b1 || bus.timer_run !== 1'b1 || bus.reveal_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL gen_done: got fr=%0d tr=%0d rr=%0d after %0d cycles, expected 1 1 1",
                     bus.field_ready, bus.timer_run, bus.reveal_ready, cyc);
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if ($countones(dut.r_mine[r]) != 2) begin
                errors++;
                $display("[TB] FAIL gen_row_mines row %0d: got %0d, expected 2",
                         r, $countones(dut.r_mine[r]));
            end
        end
    endtask

    task automatic test_loaded_reveal();
        int lat;
        loadField(16'h0003);
        checks++;
        if (bus.field_ready !== 1'b1 || bus.timer_run !== 1'b1 || bus.reveal_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_ready: got fr=%0d tr=%0d rr=%0d, expected 1 1 1",
                     bus.field_ready, bus.timer_run, bus.reveal_ready);
        end
        doReveal(3'd0, 4'd2, lat);
        checks++;
        if (lat != 10 || bus.result_mine !== 1'b0 || bus.result_count !== 4'd2) begin
            errors++;
            $display("[TB] FAIL safe_reveal_0_2: got lat=%0d mine=%0d cnt=%0d, expected 10 0 2",
                     lat, bus.result_mine, bus.result_count);
        end
        checks++;
        if (dut.r_revealCnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL reveal_counter: got %0d, expected 1", dut.r_revealCnt);
        end
        doReveal(3'd0, 4'd0, lat);
        checks++;
        if (lat != 1 || bus.result_mine !== 1'b1 || bus.result_count !== 4'd15) begin
            errors++;
            $display("[TB] FAIL mine_reveal: got lat=%0d mine=%0d cnt=%0d, expected 1 1 15",
                     lat, bus.result_mine, bus.result_count);
        end
        checks++;
        if (bus.finish !== 1'b1 || bus.timer_run !== 1'b0 || bus.reveal_ready !== 1'b0 ||
            bus.win !== 1'b0 || bus.field_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lost_flags: got fin=%0d tr=%0d rr=%0d win=%0d fr=%0d, expected 1 0 0 0 1",
                     bus.finish, bus.timer_run, bus.reveal_ready, bus.win, bus.field_ready);
        end
        step();
        checks++;
        if (bus.result_valid !== 1'b0 || bus.result_count !== 4'd15 || bus.finish !== 1'b1) begin
            errors++;
            $display("[TB] FAIL result_hold: got valid=%0d cnt=%0d fin=%0d, expected 0 15 1",
                     bus.result_valid, bus.result_count, bus.finish);
        end
    endtask

    task automatic test_reset_mid_gen();
        clearInputs();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        checks++;
        if (dut.r_state !== S_GEN || bus.finish !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_from_lost: got state=%0d fin=%0d, expected %0d 0",
                     dut.r_state, bus.finish, S_GEN);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus.reveal_ready, bus.result_valid, bus.result_mine, bus.field_ready,
             bus.timer_run, bus.finish, bus.win, bus.result_count} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL async_reset_outputs: got %b, expected all zero",
                     {bus.reveal_ready, bus.result_valid, bus.result_mine, bus.field_ready,
                      bus.timer_run, bus.finish, bus.win, bus.result_count});
        end
        checks++;
        if (dut.r_mine !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset_field: got %h, expected 0", dut.r_mine);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (dut.r_state !== S_IDLE || dut.u_lfsr.r_lfsr !== SEED) begin
            errors++;
            $display("[TB] FAIL after_release: got state=%0d lfsr=%h, expected %0d %h",
                     dut.r_state, dut.u_lfsr.r_lfsr, S_IDLE, SEED);
        end
    endtask

    task automatic test_boundaries();
        int lat;
        logic [2:0] tr [5] = '{3'd0, 3'd7, 3'd7, 3'd3, 3'd7};
        logic [3:0] tc [5] = '{4'd15, 4'd2, 4'd2, 4'd2, 4'd15};
        logic [3:0] ec [5] = '{4'd0, 4'd2, 4'd2, 4'd3, 4'd0};
        logic [7:0] en [5] = '{8'd1, 8'd2, 8'd2, 8'd3, 8'd4};
        loadField(16'h0003);
        for (int i = 0; i < 5; i++) begin
            doReveal(tr[i], tc[i], lat);
            checks++;
            if (lat != 10 || bus.result_mine !== 1'b0 || bus.result_count !== ec[i] ||
                dut.r_revealCnt !== en[i]) begin
                errors++;
                $display("[TB] FAIL edge_reveal (%0d,%0d): got lat=%0d mine=%0d cnt=%0d n=%0d, expected 10 0 %0d %0d",
                         tr[i], tc[i], lat, bus.result_mine, bus.result_count, dut.r_revealCnt, ec[i], en[i]);
            end
        end
    endtask

    task automatic test_win();
        int lat;
        int n;
        logic [3:0] exp;
        loadField(16'h0003);
        n = 0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 2; c < 16; c++) begin
                exp = (c != 2) ? 4'd0 : ((r == 0 || r == 7) ? 4'd2 : 4'd3);
                doReveal(3'(r), 4'(c), lat);
                n++;
                checks++;
                if (lat != 10 || bus.result_count !== exp) begin
                    errors++;
                    $display("[TB] FAIL win_sweep (%0d,%0d): got lat=%0d cnt=%0d, expected 10 %0d",
                             r, c, lat, bus.result_count, exp);
                end
                if (n < 112) begin
                    checks++;
                    if (bus.win !== 1'b0 || bus.finish !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL early_win after %0d: got win=%0d fin=%0d, expected 0 0",
                                 n, bus.win, bus.finish);
                    end
                end
            end
        end
        checks++;
        if (bus.win !== 1'b1 || bus.finish !== 1'b1 || bus.timer_run !== 1'b0 ||
            bus.reveal_ready !== 1'b0 || dut.r_revealCnt !== 8'd112) begin
            errors++;
            $display("[TB] FAIL won_flags: got win=%0d fin=%0d tr=%0d rr=%0d n=%0d, expected 1 1 0 0 112",
                     bus.win, bus.finish, bus.timer_run, bus.reveal_ready, dut.r_revealCnt);
        end
        step();
        checks++;
        if (bus.win !== 1'b1 || bus.result_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL won_hold: got win=%0d valid=%0d, expected 1 0", bus.win, bus.result_valid);
        end
    endtask

    task automatic test_back_to_back_start();
        int   lat;
        int   cyc;
        logic seen;
        logic rowsOk;
        loadField(16'h0003);
        doReveal(3'd0, 4'd15, lat);
        bus.reveal_valid = 1'b1;
        bus.reveal_row   = 3'd2;
        bus.reveal_col   = 4'd5;
        step();
        bus.reveal_valid = 1'b0;
        step();
        step();
        checks++;
        if (dut.r_state !== S_COUNT || dut.r_revealCnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL abort_precond: got state=%0d n=%0d, expected %0d 1",
                     dut.r_state, dut.r_revealCnt, S_COUNT);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (dut.r_state !== S_GEN || dut.r_mine !== '0 || dut.r_revealed !== '0 ||
            dut.r_revealCnt !== 8'd0 || bus.field_ready !== 1'b0 || bus.timer_run !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_clear: got state=%0d n=%0d fr=%0d tr=%0d, expected %0d 0 0 0 with empty field",
                     dut.r_state, dut.r_revealCnt, bus.field_ready, bus.timer_run, S_GEN);
        end
        seen = 1'b0;
        cyc  = 0;
        while (!bus.field_ready && cyc < 2000) begin
            if (bus.result_valid) seen = 1'b1;
            step();
            cyc++;
        end
        if (bus.result_valid) seen = 1'b1;
        checks++;
        if (seen !== 1'b0 || bus.field_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_regen: got stray_result=%0d fr=%0d, expected 0 1", seen, bus.field_ready);
        end
        rowsOk = 1'b1;
        for (int r = 0; r < 8; r++) begin
            if ($countones(dut.r_mine[r]) != 2) rowsOk = 1'b0;
        end
        checks++;
        if (rowsOk !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_new_field: got rows_ok=%0d, expected 1", rowsOk);
        end
        bus.start        = 1'b1;
        bus.reveal_valid = 1'b1;
        step();
        clearInputs();
        checks++;
        if (dut.r_state !== S_GEN || bus.result_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_beats_reveal: got state=%0d valid=%0d, expected %0d 0",
                     dut.r_state, bus.result_valid, S_GEN);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        $display("[TB] mine_field_ctrl bench starting");
        test_reset();
        test_gen();
        test_loaded_reveal();
        test_reset_mid_gen();
        test_boundaries();
        test_win();
        test_back_to_back_start();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
